// File: rtl/dct_ser_pkg.sv
// Shared constants, component encodings, FSM state type and the JPEG zigzag
// scan table for the DCT block serializer.
package dct_ser_pkg;

    localparam int BLOCK_SIZE = 64;
    localparam int NUM_COMPS  = 3;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    // Scan step -> raster position (row*8+col), standard JPEG zigzag.
    localparam logic [5:0] ZIGZAG_TABLE [BLOCK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/dct_zigzag_rom.sv
// Combinational zigzag lookup: scan step in, raster position out.
module dct_zigzag_rom
    import dct_ser_pkg::*;
(
    input  logic [5:0] step_i,
    output logic [5:0] raster_o
);

    assign raster_o = ZIGZAG_TABLE[step_i];

endmodule

// File: rtl/dct_block_serializer.sv
// Captures one 8x8 Y/Cb/Cr DCT block and streams its 192 coefficients one per
// beat. Define DCT_SERIALIZER_ZIGZAG_EN for zigzag order; raster order otherwise.
module dct_block_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = dct_ser_pkg::BLOCK_SIZE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] in_y_dct,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] in_cb_dct,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] in_cr_dct,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [1:0]                       out_comp,
    output logic [5:0]                       out_index,
    output logic                             out_last_comp,
    output logic                             out_last
);

    import dct_ser_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(BLOCK_SIZE - 1);

    state_e     state_q, state_d;
    logic [1:0] comp_q,  comp_d;
    logic [5:0] cnt_q,   cnt_d;
    logic [5:0] raster;
    logic       capture;

    logic [DATA_WIDTH-1:0] coef_mem_q [NUM_COMPS][BLOCK_SIZE];

    assign capture = (state_q == ST_IDLE) && in_valid;

`ifdef DCT_SERIALIZER_ZIGZAG_EN
    dct_zigzag_rom u_zigzag_rom (
        .step_i   (cnt_q),
        .raster_o (raster)
    );
`else
    assign raster = cnt_q;
`endif

    // NOTE: the coefficient buffer is deliberately left out of reset; it is
    // always fully rewritten on capture before any word is read.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                coef_mem_q[0][i] <= in_y_dct [i*DATA_WIDTH +: DATA_WIDTH];
                coef_mem_q[1][i] <= in_cb_dct[i*DATA_WIDTH +: DATA_WIDTH];
                coef_mem_q[2][i] <= in_cr_dct[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            comp_q  <= COMP_Y;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        comp_d  = comp_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SEND;
                    comp_d  = COMP_Y;
                    cnt_d   = '0;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (cnt_q != LAST_IDX) begin
                        cnt_d = cnt_q + 6'd1;
                    end else if (comp_q != COMP_CR) begin
                        cnt_d  = '0;
                        comp_d = comp_q + 2'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        comp_d  = COMP_Y;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs come only from registered state, so out_valid has no path from out_ready.
    always_comb begin
        in_ready      = (state_q == ST_IDLE);
        out_valid     = (state_q == ST_SEND);
        out_data      = '0;
        out_comp      = '0;
        out_index     = '0;
        out_last_comp = 1'b0;
        out_last      = 1'b0;
        if (state_q == ST_SEND) begin
            out_data      = coef_mem_q[comp_q][raster];
            out_comp      = comp_q;
            out_index     = cnt_q;
            out_last_comp = (cnt_q == LAST_IDX);
            out_last      = (cnt_q == LAST_IDX) && (comp_q == COMP_CR);
        end
    end

endmodule

// File: tb/tb_dct_block_serializer.sv
// Randomized self-checking bench for dct_block_serializer against a
// block-level reference (scan order derived by walking the 8x8 diagonals).
module tb_dct_block_serializer;

    localparam int W  = 32;
    localparam int BS = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [BS*W-1:0]   in_y_dct, in_cb_dct, in_cr_dct;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [1:0]        out_comp;
    logic [5:0]        out_index;
    logic              out_last_comp;
    logic              out_last;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] blk [3][BS];
    logic [W-1:0] nxt [3][BS];
    int           zz  [BS];

    always #5 clk = ~clk;

    dct_block_serializer #(.DATA_WIDTH(W), .BLOCK_SIZE(BS)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_y_dct      (in_y_dct),
        .in_cb_dct     (in_cb_dct),
        .in_cr_dct     (in_cr_dct),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_comp      (out_comp),
        .out_index     (out_index),
        .out_last_comp (out_last_comp),
        .out_last      (out_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scan order: diagonals s = row+col, even diagonals run upward (row falling).
    task automatic build_scan();
        int idx = 0;
`ifdef DCT_SERIALIZER_ZIGZAG_EN
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[idx] = r * 8 + (s - r);
                    idx++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[idx] = r * 8 + (s - r);
                    idx++;
                end
            end
        end
`else
        for (int k = 0; k < BS; k++) zz[k] = k;
        idx = BS;
`endif
        if (idx != BS) $fatal(1, "FAIL scan_build: %0d entries", idx);
    endtask

    task automatic fill_blk(input bit counting);
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < BS; i++)
                blk[c][i] = counting ? W'(c * 256 + i) : $urandom;
    endtask

    task automatic fill_nxt();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < BS; i++)
                nxt[c][i] = $urandom;
    endtask

    task automatic drive_bus(input bit use_nxt);
        for (int i = 0; i < BS; i++) begin
            in_y_dct [i*W +: W] = use_nxt ? nxt[0][i] : blk[0][i];
            in_cb_dct[i*W +: W] = use_nxt ? nxt[1][i] : blk[1][i];
            in_cr_dct[i*W +: W] = use_nxt ? nxt[2][i] : blk[2][i];
        end
    endtask

    function automatic logic [63:0] expect_beat(input int n);
        int c = n / BS;
        int k = n % BS;
        return {21'd0, 1'b1, 2'(c), 6'(k), (k == BS - 1), (n == 3 * BS - 1), blk[c][zz[k]]};
    endfunction

    function automatic logic [63:0] observed();
        return {21'd0, out_valid, out_comp, out_index, out_last_comp, out_last, out_data};
    endfunction

    // Called at a negedge while idle: present blk and confirm one-cycle capture.
    task automatic start_block();
        drive_bus(1'b0);
        check("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("capture_out_valid", out_valid, 1);
        check("capture_in_ready", in_ready, 0);
    endtask

    // Consume one block; ready_pct% chance of out_ready per cycle. inject_at >= 0
    // presents nxt with in_valid from that beat on; reset_at >= 0 pulses rst there.
    task automatic stream(input int ready_pct, input int inject_at, input int reset_at);
        int n = 0;
        int cyc = 0;
        bit rdy;
        while (n < 3 * BS && cyc < 4000) begin
            if (n == reset_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_mid_out_valid", out_valid, 0);
                check("rst_mid_in_ready", in_ready, 1);
                check("rst_mid_out_index", out_index, 0);
                return;
            end
            check($sformatf("beat%0d", n), observed(), expect_beat(n));
            if (inject_at >= 0 && n >= inject_at) begin
                drive_bus(1'b1);
                in_valid = 1'b1;
                check("send_in_ready", in_ready, 0);
            end
            rdy = ($urandom_range(99) < ready_pct);
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) n++;
        end
        check("stream_timeout", (cyc < 4000), 1);
        if (ready_pct >= 100) check("stream_cycles", cyc, 3 * BS);
        check("post_last_in_ready", in_ready, 1);
        check("post_last_idle_outs", observed(), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_y_dct  = '0;
        in_cb_dct = '0;
        in_cr_dct = '0;
        build_scan();

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_outs", observed(), 64'd0);
        @(negedge clk);
        check("idle_hold_outs", observed(), 64'd0);

        // Counting pattern, no stalls.
        fill_blk(1'b1);
        start_block();
        stream(100, -1, -1);

        // Random data under random backpressure.
        fill_blk(1'b0);
        start_block();
        stream(50, -1, -1);

        // in_valid with other data during SEND, held into back-to-back accept.
        fill_blk(1'b0);
        fill_nxt();
        start_block();
        stream(100, 10, -1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_out_valid", out_valid, 1);
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < BS; i++)
                blk[c][i] = nxt[c][i];

        // Stream the back-to-back block, abort it with rst at beat 100.
        stream(100, -1, 100);

        // Fresh block after the abort starts from Y index 0.
        fill_blk(1'b0);
        start_block();
        check("restart_index", {out_comp, out_index}, 8'd0);
        stream(70, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
